// File: rtl/bb1_pkg.sv
// Shared types for the K1802BB1 port master.
//   op_t    : command opcode carried on cmd_op and stored in the command FIFO
//   state_t : port sequencer states
package bb1_pkg;

  typedef enum logic [1:0] {
    OpRead  = 2'd0,
    OpWrite = 2'd1,
    OpXchg  = 2'd2,
    OpRsvd  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd   = 3'd1,
    StWr   = 3'd2,
    StXrd  = 3'd3,
    StXwr  = 3'd4
  } state_t;

  localparam int unsigned OpW   = 2;
  localparam int unsigned AddrW = 2;

endpackage

// File: rtl/bb1_cmd_fifo.sv
// Two-entry command FIFO holding {op, addr, wdata}.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write wdata_i (ignored when full)
//   pop_i         : drop head entry (ignored when empty)
//   rdata_o       : head entry, valid while !empty_o
//   full_o/empty_o: occupancy flags
module bb1_cmd_fifo #(
  parameter int unsigned Width = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push_en, pop_en;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = ~wr_ptr_q;
    if (pop_en)  rd_ptr_d = ~rd_ptr_q;
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_en) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/bb1_port_master.sv
// Port master for a bank of SLICES K1802BB1 chips sharing one port.
//   clk, nRESET          : clock, asynchronous active-low reset
//   cmd_*                : command channel (valid/ready), op/addr/wdata
//   rsp_*                : response channel (valid/ready), data/err
//   nEC nW nR A nCI nD_o : registered active-low chip port drive
//   nD_i                 : inverted read data from the chips
module bb1_port_master
  import bb1_pkg::*;
#(
  parameter int unsigned SLICES = 4
) (
  input  logic                  clk,
  input  logic                  nRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [1:0]            cmd_addr,
  input  logic [4*SLICES-1:0]   cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [4*SLICES-1:0]   rsp_data,
  output logic                  rsp_err,
  output logic                  nEC,
  output logic                  nW,
  output logic                  nR,
  output logic [1:0]            A,
  output logic                  nCI,
  output logic [4*SLICES-1:0]   nD_o,
  input  logic [4*SLICES-1:0]   nD_i
);

  localparam int unsigned W      = 4 * SLICES;
  localparam int unsigned EntryW = OpW + AddrW + W;

  // FIFO
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [EntryW-1:0] fifo_rdata;
  op_t               head_op;
  logic [1:0]        head_addr;
  logic [W-1:0]      head_wdata;

  bb1_cmd_fifo #(
    .Width (EntryW)
  ) u_cmd_fifo (
    .clk_i   (clk),
    .rst_ni  (nRESET),
    .push_i  (cmd_valid),
    .pop_i   (fifo_pop),
    .wdata_i ({cmd_op, cmd_addr, cmd_wdata}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cmd_ready  = ~fifo_full;
  assign head_op    = op_t'(fifo_rdata[EntryW-1 -: OpW]);
  assign head_addr  = fifo_rdata[W +: AddrW];
  assign head_wdata = fifo_rdata[W-1:0];

  // State
  state_t       state_q, state_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_err_q, rsp_err_d;
  logic         nec_q, nec_d, nw_q, nw_d, nr_q, nr_d, nci_q, nci_d;
  logic [1:0]   a_q, a_d;
  logic [W-1:0] nd_q, nd_d;
  // Write half of an exchange, held across the read cycle
  logic [W-1:0] xwdata_q, xwdata_d;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    xwdata_d    = xwdata_q;
    fifo_pop    = 1'b0;
    // Chip port idles unless a state below drives it for the next cycle
    nec_d = 1'b1;
    nw_d  = 1'b1;
    nr_d  = 1'b1;
    nci_d = 1'b1;
    a_d   = 2'd0;
    nd_d  = '1;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !rsp_valid_q) begin
          fifo_pop = 1'b1;
          unique case (head_op)
            OpRead: begin
              state_d = StRd;
              nec_d   = 1'b0;
              nr_d    = 1'b0;
              a_d     = head_addr;
            end
            OpWrite: begin
              state_d = StWr;
              nec_d   = 1'b0;
              nw_d    = 1'b0;
              a_d     = head_addr;
              nd_d    = ~head_wdata;
              nci_d   = (head_addr != 2'd0);
            end
            OpXchg: begin
              state_d  = StXrd;
              nec_d    = 1'b0;
              nr_d     = 1'b0;
              a_d      = head_addr;
              xwdata_d = head_wdata;
            end
            default: begin
              // Reserved op: error response, no chip cycle
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_data_d  = '0;
            end
          endcase
        end
      end
      StRd: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = ~nD_i;
      end
      StWr: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
      end
      StXrd: begin
        // Capture old value silently, then reuse the held address for the write
        state_d    = StXwr;
        rsp_err_d  = 1'b0;
        rsp_data_d = ~nD_i;
        nec_d      = 1'b0;
        nw_d       = 1'b0;
        a_d        = a_q;
        nd_d       = ~xwdata_q;
        nci_d      = (a_q != 2'd0);
      end
      StXwr: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= StIdle;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      xwdata_q    <= '0;
      nec_q       <= 1'b1;
      nw_q        <= 1'b1;
      nr_q        <= 1'b1;
      nci_q       <= 1'b1;
      a_q         <= 2'd0;
      nd_q        <= '1;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      xwdata_q    <= xwdata_d;
      nec_q       <= nec_d;
      nw_q        <= nw_d;
      nr_q        <= nr_d;
      nci_q       <= nci_d;
      a_q         <= a_d;
      nd_q        <= nd_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign nEC       = nec_q;
  assign nW        = nw_q;
  assign nR        = nr_q;
  assign nCI       = nci_q;
  assign A         = a_q;
  assign nD_o      = nd_q;

endmodule

// File: tb/tb_bb1_port_master.sv
module tb_bb1_port_master;

  localparam int unsigned SLICES = 4;
  localparam int unsigned W      = 4 * SLICES;

  logic         clk = 1'b0;
  logic         nRESET;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_op, cmd_addr;
  logic [W-1:0] cmd_wdata;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0] rsp_data;
  logic         nEC, nW, nR, nCI;
  logic [1:0]   A;
  logic [W-1:0] nD_o, nD_i;

  bb1_port_master #(
    .SLICES (SLICES)
  ) dut (
    .clk       (clk),
    .nRESET    (nRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .nEC       (nEC),
    .nW        (nW),
    .nR        (nR),
    .A         (A),
    .nCI       (nCI),
    .nD_o      (nD_o),
    .nD_i      (nD_i)
  );

  always #5 clk = ~clk;

  // K1802BB1 bank: RG1-RG3 latch on the negedge, RG0 on the closing posedge
  logic [W-1:0] chip_rg [4];
  always @(negedge clk) if (!nEC && !nW && A != 2'd0) chip_rg[A] <= ~nD_o;
  always @(posedge clk) if (!nEC && !nW && A == 2'd0) chip_rg[0] <= ~nD_o;
  assign nD_i = (!nEC && !nR) ? ~chip_rg[A] : '1;

  // Reference model: register contents in command order, expected responses
  typedef struct {
    logic [W-1:0] data;
    logic         err;
  } exp_t;
  logic [W-1:0] ref_rg [4];
  exp_t         exp_q [$];

  int n_cmp  = 0;
  int n_fail = 0;
  bit saw_nec_low = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    if (nRESET) begin
      if (nEC) begin
        check("idle_levels", {nW, nR, nCI, 14'd0, A, nD_o}, {3'b111, 14'd0, 2'd0, {W{1'b1}}});
      end else begin
        saw_nec_low = 1'b1;
        check("one_strobe", {31'd0, nR ^ nW}, 32'd1);
        if (!nW) check("nci_vs_addr", {31'd0, nCI}, {31'd0, A != 2'd0});
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          check("rsp_data", {16'd0, rsp_data}, {16'd0, exp_q[0].data});
          check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic push(input logic [1:0] op, input logic [1:0] addr, input logic [W-1:0] d);
    exp_t e;
    int   t;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cmd_ready) begin
      check("push_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    e.data = '0;
    e.err  = 1'b0;
    case (op)
      2'd0: e.data = ref_rg[addr];
      2'd1: ref_rg[addr] = d;
      2'd2: begin e.data = ref_rg[addr]; ref_rg[addr] = d; end
      default: e.err = 1'b1;
    endcase
    exp_q.push_back(e);
  endtask

  // Waits for a response (current cycle included), checks it, lets it be consumed
  task automatic wait_rsp(input string name, input logic [W-1:0] d, input logic err);
    int t;
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!rsp_valid) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({name, "_data"}, {16'd0, rsp_data}, {16'd0, d});
    check({name, "_err"}, {31'd0, rsp_err}, {31'd0, err});
    @(posedge clk); #1;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nRESET    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 2'd0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    #22;
    // Reset state
    check("rst_rsp", {rsp_valid, rsp_err, 14'd0, rsp_data}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_chip", {nEC, nW, nR, nCI, 12'd0, A, nD_o}, {4'hF, 12'd0, 2'd0, 16'hFFFF});
    step();
    nRESET = 1'b1;
    step();

    // WRITE RG2 then READ RG2
    push(2'd1, 2'd2, 16'hA5C3);
    step();
    check("wr_strobes", {28'd0, nEC, nW, nR, nCI}, {28'd0, 4'b0011});
    check("wr_addr", {30'd0, A}, 32'd2);
    check("wr_nd", {16'd0, nD_o}, 32'h5A3C);
    step();
    check("wr_rsp", {15'd0, rsp_valid, rsp_data}, {15'd0, 1'b1, 16'h0000});
    step();
    push(2'd0, 2'd2, 16'h0000);
    step();
    check("rd_strobes", {29'd0, nEC, nR, nW}, 32'b001);
    step();
    check("rd_rsp", {15'd0, rsp_valid, rsp_data}, {15'd0, 1'b1, 16'hA5C3});
    step();

    // XCHG on RG1
    push(2'd1, 2'd1, 16'h1234);
    wait_rsp("pre_rg1", 16'h0000, 1'b0);
    push(2'd2, 2'd1, 16'hFFFF);
    step();
    check("x_rd", {29'd0, nEC, nR, nW}, 32'b001);
    step();
    check("x_wr", {13'd0, nEC, nW, nR, nD_o}, {13'd0, 3'b001, 16'h0000});
    check("x_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
    step();
    check("x_rsp", {15'd0, rsp_valid, rsp_data}, {15'd0, 1'b1, 16'h1234});
    step();
    push(2'd0, 2'd1, 16'h0000);
    wait_rsp("x_after", 16'hFFFF, 1'b0);

    // Back-pressure: three reads while response is stalled
    push(2'd1, 2'd3, 16'h3333);
    wait_rsp("pre_rg3", 16'h0000, 1'b0);
    rsp_ready = 1'b0;
    push(2'd0, 2'd1, 16'h0000);
    push(2'd0, 2'd2, 16'h0000);
    push(2'd0, 2'd3, 16'h0000);
    check("bp_full", {30'd0, cmd_ready, rsp_valid}, 32'b01);
    repeat (3) step();
    check("bp_hold", {14'd0, cmd_ready, rsp_valid, rsp_data}, {14'd0, 2'b01, 16'hFFFF});
    rsp_ready = 1'b1;
    wait_rsp("bp_r1", 16'hFFFF, 1'b0);
    wait_rsp("bp_r2", 16'hA5C3, 1'b0);
    wait_rsp("bp_r3", 16'h3333, 1'b0);
    check("bp_ready", {31'd0, cmd_ready}, 32'd1);

    // Reserved op
    saw_nec_low = 1'b0;
    push(2'd3, 2'd0, 16'hBEEF);
    wait_rsp("rsvd", 16'h0000, 1'b1);
    check("rsvd_no_cycle", {31'd0, saw_nec_low}, 32'd0);

    // nCI only on RG0 writes
    push(2'd1, 2'd0, 16'h0F0F);
    step();
    check("wr0_nci", {29'd0, nW, nCI, A == 2'd0}, 32'b001);
    wait_rsp("wr0", 16'h0000, 1'b0);
    push(2'd1, 2'd3, 16'h0F0F);
    step();
    check("wr3_nci", {29'd0, nW, nCI, A == 2'd3}, 32'b011);
    wait_rsp("wr3", 16'h0000, 1'b0);
    push(2'd0, 2'd0, 16'h0000);
    wait_rsp("rd0", 16'h0F0F, 1'b0);

    // Reset during a write to RG1, before its latching negedge
    push(2'd1, 2'd1, 16'hBEEF);
    step();
    check("rstw_active", {30'd0, nEC, nW}, 32'b00);
    nRESET = 1'b0;
    #1;
    check("rstw_inactive", {14'd0, nEC, nW, nD_o}, {14'd0, 2'b11, 16'hFFFF});
    exp_q.delete();
    ref_rg[1] = 16'hFFFF;
    step();
    nRESET = 1'b1;
    check("rstw_after", {30'd0, rsp_valid, cmd_ready}, 32'b01);
    repeat (5) step();
    check("rstw_quiet", {31'd0, rsp_valid}, 32'd0);
    push(2'd0, 2'd1, 16'h0000);
    wait_rsp("rstw_lost", 16'hFFFF, 1'b0);

    repeat (3) step();
    check("drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
